// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Iterative RV32M multiply/divide unit with a valid/ready interface.
//            It uses a shift-add multiplier and a restoring divider on operand
//            magnitudes, with the sign fixed up in the last iteration.
// Ports    : CLK, RESET_N (async, active low)
//            IN_VALID/IN_READY, FUNC3, DATA1, DATA2 : request handshake
//            OUT_VALID/OUT_READY, RESULT             : response handshake
//            KILL : flush the in-flight op; BUSY : high in CALC or DONE
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [2:0]      FUNC3,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic            KILL,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] RESULT,
    output logic            BUSY
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    localparam logic [XLEN-1:0] C_MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] C_ALL_ONES = {XLEN{1'b1}};

    state_t              state_q, state_d;
    logic [4:0]          count_q, count_d;
    logic [2:0]          func_q, func_d;
    logic [XLEN-1:0]     a_q, a_d;        // multiplicand, or dividend/quotient shifter
    logic [XLEN-1:0]     b_q, b_d;        // divisor magnitude
    logic [2*XLEN-1:0]   acc_q, acc_d;    // product accumulator, multiplier in low half
    logic [XLEN-1:0]     rem_q, rem_d;    // partial remainder
    logic                negq_q, negq_d;  // negate product / quotient
    logic                negr_q, negr_d;  // negate remainder
    logic [XLEN-1:0]     result_q, result_d;

    // Accept-time decode
    logic            s1, s2, dz, ovf;
    logic [XLEN-1:0] mag1, mag2;

    // One iteration of each engine
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] acc_nx;
    logic [XLEN:0]     div_shift;         // 33-bit partial remainder after shift
    logic [XLEN+1:0]   div_trial;
    logic              div_bit;
    logic [XLEN-1:0]   rem_nx, quo_nx;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    // A successful trial subtraction leaves a value below the divisor, so
    // bit XLEN of the trial is always zero when it is kept.
    logic unused_bits;
    assign unused_bits = div_trial[XLEN];

    always_comb begin
        s1 = DATA1[XLEN-1] & ((FUNC3 == F_MULH) | (FUNC3 == F_MULHSU) |
                              (FUNC3 == F_DIV)  | (FUNC3 == F_REM));
        s2 = DATA2[XLEN-1] & ((FUNC3 == F_MULH) | (FUNC3 == F_DIV) |
                              (FUNC3 == F_REM));
        mag1 = s1 ? -DATA1 : DATA1;
        mag2 = s2 ? -DATA2 : DATA2;
        dz   = (DATA2 == '0);
        ovf  = ((FUNC3 == F_DIV) | (FUNC3 == F_REM)) &
               (DATA1 == C_MIN_NEG) & (DATA2 == C_ALL_ONES);

        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        acc_nx  = {mul_sum, acc_q[XLEN-1:1]};

        div_shift = {rem_q, a_q[XLEN-1]};
        div_trial = {1'b0, div_shift} - {2'b00, b_q};
        div_bit   = ~div_trial[XLEN+1];
        rem_nx    = div_bit ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
        quo_nx    = {a_q[XLEN-2:0], div_bit};

        prod_fix = negq_q ? -acc_nx : acc_nx;
        quo_fix  = negq_q ? -quo_nx : quo_nx;
        rem_fix  = negr_q ? -rem_nx : rem_nx;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        func_d   = func_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (IN_VALID) begin
                    func_d  = FUNC3;
                    a_d     = mag1;
                    b_d     = mag2;
                    acc_d   = {{XLEN{1'b0}}, mag2};
                    rem_d   = '0;
                    count_d = '0;
                    // A zero divisor must not flip the all-ones quotient.
                    negq_d  = (s1 ^ s2) & ~dz;
                    negr_d  = s1;
                    if (EARLY_OUT && FUNC3[2] && dz) begin
                        result_d = FUNC3[1] ? DATA1 : C_ALL_ONES;
                        state_d  = S_DONE;
                    end else if (EARLY_OUT && ovf) begin
                        result_d = FUNC3[1] ? '0 : C_MIN_NEG;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (KILL) begin
                    state_d = S_IDLE;
                end else begin
                    count_d = count_q + 5'd1;
                    if (!func_q[2]) begin
                        acc_d = acc_nx;
                    end else begin
                        a_d   = quo_nx;
                        rem_d = rem_nx;
                    end
                    if (count_q == 5'd31) begin
                        if (!func_q[2]) begin
                            result_d = (func_q == F_MUL) ? prod_fix[XLEN-1:0]
                                                         : prod_fix[2*XLEN-1:XLEN];
                        end else begin
                            result_d = func_q[1] ? rem_fix : quo_fix;
                        end
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (KILL || OUT_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            func_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            func_q   <= func_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

    assign IN_READY  = (state_q == S_IDLE);
    assign OUT_VALID = (state_q == S_DONE);
    assign BUSY      = (state_q != S_IDLE);
    assign RESULT    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Purpose  : Scoreboard bench for muldiv_seq. It runs two instances side by
//            side, with EARLY_OUT=1 and EARLY_OUT=0, on shared inputs. Each
//            instance has its own expected-response queue holding the result
//            and the latency in cycles from the accept cycle to OUT_VALID.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  func3;
    logic [31:0] d1, d2;
    logic        kill;
    logic        out_ready;

    logic        eo_in_ready, eo_out_valid, eo_busy;
    logic [31:0] eo_result;
    logic        it_in_ready, it_out_valid, it_busy;
    logic [31:0] it_result;

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(32), .EARLY_OUT(1'b1)) dut_eo (
        .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(eo_in_ready),
        .FUNC3(func3), .DATA1(d1), .DATA2(d2), .KILL(kill),
        .OUT_VALID(eo_out_valid), .OUT_READY(out_ready), .RESULT(eo_result),
        .BUSY(eo_busy)
    );

    muldiv_seq #(.XLEN(32), .EARLY_OUT(1'b0)) dut_it (
        .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(it_in_ready),
        .FUNC3(func3), .DATA1(d1), .DATA2(d2), .KILL(kill),
        .OUT_VALID(it_out_valid), .OUT_READY(out_ready), .RESULT(it_result),
        .BUSY(it_busy)
    );

    typedef struct {
        string       name;
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t q_eo[$];
    exp_t q_it[$];

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- monitor ----------------
    int cyc = 0;
    int acc_eo = 0, acc_it = 0;
    bit pv_eo = 1'b0, pv_it = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            pv_eo = 1'b0;
            pv_it = 1'b0;
        end else begin
            if (eo_out_valid && !pv_eo) begin
                n_tests++;
                if (q_eo.size() == 0) begin
                    n_fail++;
                    $display("FAIL eo_unexpected: result %h delivered, expected no output", eo_result);
                end else begin
                    e = q_eo.pop_front();
                    if (eo_result !== e.res || (cyc - acc_eo) != e.lat) begin
                        n_fail++;
                        $display("FAIL eo_%s: result %h latency %0d, expected %h latency %0d",
                                 e.name, eo_result, cyc - acc_eo, e.res, e.lat);
                    end
                end
            end
            if (it_out_valid && !pv_it) begin
                n_tests++;
                if (q_it.size() == 0) begin
                    n_fail++;
                    $display("FAIL it_unexpected: result %h delivered, expected no output", it_result);
                end else begin
                    e = q_it.pop_front();
                    if (it_result !== e.res || (cyc - acc_it) != e.lat) begin
                        n_fail++;
                        $display("FAIL it_%s: result %h latency %0d, expected %h latency %0d",
                                 e.name, it_result, cyc - acc_it, e.res, e.lat);
                    end
                end
            end
            if (in_valid && eo_in_ready) acc_eo = cyc;
            if (in_valid && it_in_ready) acc_it = cyc;
            pv_eo = eo_out_valid;
            pv_it = it_out_valid;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_eo_in_ready"},  {31'b0, eo_in_ready},  32'd1);
        chk({nm, "_eo_out_valid"}, {31'b0, eo_out_valid}, 32'd0);
        chk({nm, "_eo_result"},    eo_result,             32'd0);
        chk({nm, "_eo_busy"},      {31'b0, eo_busy},      32'd0);
        chk({nm, "_it_in_ready"},  {31'b0, it_in_ready},  32'd1);
        chk({nm, "_it_out_valid"}, {31'b0, it_out_valid}, 32'd0);
        chk({nm, "_it_result"},    it_result,             32'd0);
        chk({nm, "_it_busy"},      {31'b0, it_busy},      32'd0);
    endtask

    // Called #1 after a rising edge with both units idle. The request is
    // accepted at the next edge; afterwards the operands are scrambled.
    task automatic issue(input string nm, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_eo, input logic [31:0] exp_it,
                         input int lat_eo, input int lat_it,
                         input bit push, input bit kill_at_accept);
        exp_t e;
        in_valid = 1'b1;
        func3    = f;
        d1       = a;
        d2       = b;
        kill     = kill_at_accept;
        if (push) begin
            e.name = nm; e.res = exp_eo; e.lat = lat_eo; q_eo.push_back(e);
            e.name = nm; e.res = exp_it; e.lat = lat_it; q_it.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        kill     = 1'b0;
        func3    = 3'($urandom);
        d1       = $urandom;
        d2       = $urandom;
    endtask

    task automatic wait_idle(input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (eo_in_ready && it_in_ready) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: in_ready eo=%b it=%b, expected both 1 within 100 cycles",
                     nm, eo_in_ready, it_in_ready);
        end
    endtask

    task automatic run(input string nm, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input int lat_eo);
        issue(nm, f, a, b, exp_r, exp_r, lat_eo, 33, 1'b1, 1'b0);
        wait_idle(nm);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        func3     = 3'b000;
        d1        = '0;
        d2        = '0;
        kill      = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Multiplies
        run("mul_7_m3",      3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run("mulh_m1_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run("mulhsu_m1_max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run("mulhu_max_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run("mul_6_7",       3'b000, 32'd6,         32'd7,         32'd42,        33);

        // Divides
        run("div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run("rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run("divu_100_7",    3'b101, 32'd100,       32'd7,         32'd14,        33);
        run("remu_100_7",    3'b111, 32'd100,       32'd7,         32'd2,         33);

        // Divide by zero: early-out unit answers in 1 cycle, other in 33
        run("div_5_0",       3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run("divu_5_0",      3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run("rem_5_0",       3'b110, 32'd5,         32'd0,         32'd5,         1);
        run("remu_5_0",      3'b111, 32'd5,         32'd0,         32'd5,         1);
        run("div_m5_0",      3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1);
        run("rem_m5_0",      3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1);

        // Signed overflow
        run("rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Overflow DIV with the consumer stalled for 5 cycles
        out_ready = 1'b0;
        issue("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h8000_0000, 32'h8000_0000, 1, 33, 1'b1, 1'b0);
        for (int i = 0; i < 60 && !it_out_valid; i++) begin
            @(posedge clk); #1;
        end
        repeat (5) begin
            @(posedge clk); #1;
            chk("hold_eo_out_valid", {31'b0, eo_out_valid}, 32'd1);
            chk("hold_eo_result",    eo_result,             32'h8000_0000);
            chk("hold_eo_in_ready",  {31'b0, eo_in_ready},  32'd0);
            chk("hold_it_out_valid", {31'b0, it_out_valid}, 32'd1);
            chk("hold_it_result",    it_result,             32'h8000_0000);
            chk("hold_it_in_ready",  {31'b0, it_in_ready},  32'd0);
        end
        out_ready = 1'b1;
        wait_idle("div_ovf");

        // KILL at CALC count 10
        issue("kill_mul", 3'b000, 32'd3, 32'd4, 32'd0, 32'd0, 33, 33, 1'b0, 1'b0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_eo_in_ready",  {31'b0, eo_in_ready},  32'd1);
        chk("kill_eo_out_valid", {31'b0, eo_out_valid}, 32'd0);
        chk("kill_eo_busy",      {31'b0, eo_busy},      32'd0);
        chk("kill_it_in_ready",  {31'b0, it_in_ready},  32'd1);
        chk("kill_it_out_valid", {31'b0, it_out_valid}, 32'd0);
        chk("kill_it_busy",      {31'b0, it_busy},      32'd0);
        run("after_kill_mul", 3'b000, 32'd11, 32'd13, 32'd143, 33);

        // KILL while idle does not block an accept in the same cycle
        issue("kill_idle_divu", 3'b101, 32'd100, 32'd7, 32'd14, 32'd14, 33, 33, 1'b1, 1'b1);
        wait_idle("kill_idle_divu");

        // Asynchronous reset mid-CALC
        issue("reset_mul", 3'b000, 32'd5, 32'd5, 32'd0, 32'd0, 33, 33, 1'b0, 1'b0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run("after_reset_remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);

        repeat (3) @(posedge clk);
        #1;
        chk("eo_queue_empty", 32'(q_eo.size()), 32'd0);
        chk("it_queue_empty", 32'(q_it.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
